alu_rr_arbiter: RTL
===================

Name: alu_rr_arbiter

Overview:
- Shares one 8-bit arithmetic_unit (add, increment, subtract, decrement; NZVC flags) between two independent requesters.
- Accepts operations over valid/ready handshakes and arbitrates round-robin.
- Drives the unit's A/B/sel inputs from registers, captures result and flags, and returns them on a tagged response channel.
- Sits between the two instruction-issue paths and the shared arithmetic datapath.

Parameters:
- PRIO_INIT, 0: requester that wins the first contested arbitration after reset (0 or 1).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- req0_valid  in  1  requester 0 has an operation
- req0_ready  out  1  requester 0 operation accepted this cycle
- req0_a  in  8  operand A, requester 0
- req0_b  in  8  operand B, requester 0
- req0_op  in  2  00 A+B, 01 A+1, 10 A-B, 11 A-1
- req1_valid, req1_ready, req1_a, req1_b, req1_op  same widths, requester 1
- au_a  out  8  operand A to arithmetic_unit (registered)
- au_b  out  8  operand B to arithmetic_unit (registered)
- au_sel  out  2  operation select to arithmetic_unit (registered)
- au_result  in  8  arithmetic_unit result (combinational from au_a/au_b/au_sel)
- au_nzvc  in  4  arithmetic_unit flags {N,Z,V,C}
- rsp_valid  out  1  response available
- rsp_ready  in  1  consumer accepts response
- rsp_id  out  1  requester the response belongs to
- rsp_result  out  8  captured result
- rsp_nzvc  out  4  captured flags
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, last_grant=~PRIO_INIT.
  - au_a, au_b, au_sel, rsp_result, rsp_nzvc and rsp_id all 0.
  - rsp_valid=0, busy=0, both reqN_ready=0.
  - Reset mid-operation discards any in-flight operation and any unconsumed response.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - Only one requester valid: that requester is granted.
  - Both valid: grant goes to ~last_grant.
  - reqN_ready is combinational and equals (state==IDLE && grant==N). At most one ready is high, and ready never rises without the matching valid.
  - On acceptance: latch a, b, op into au_a, au_b, au_sel; latch the id; set last_grant=N; go to EXEC.
  - No valid: stay in IDLE; the au_* registers hold their old values.
- EXEC (exactly 1 cycle): at the clock edge, register au_result into rsp_result and au_nzvc into rsp_nzvc, then go to RESP.
- RESP:
  - rsp_valid=1 and rsp_id/result/nzvc are held stable.
  - When rsp_valid && rsp_ready: go to IDLE, and rsp_valid falls the next cycle. rsp_* data keeps its last value.
  - No requests are accepted while in RESP.
  - rsp_ready low holds RESP indefinitely; back-pressure stalls both requesters.
- Latency: accept at edge T; response visible T+2; earliest next accept T+3 (when rsp_ready=1 at T+2). Peak throughput is one operation per 3 cycles.
- The requester is responsible for holding a/b/op stable while valid is high and ready is low; the arbiter samples them only on acceptance.
- Fairness: a continuously valid loser is guaranteed service on the next arbitration. Maximum wait is one foreign operation.
- Arithmetic is modulo 256. Flags are taken from the unit unchanged: N=result[7], Z=(result==0), V=signed overflow, C=carry-out (subtract: C=1 means no borrow).
- Requester valid deasserting while in EXEC or RESP is legal and has no effect.

Decomposition:
- Shared package/header: op encodings (OP_ADD=2'b00, OP_INC=2'b01, OP_SUB=2'b10, OP_DEC=2'b11), state encodings, flag bit indices (N=3, Z=2, V=1, C=0).
- One natural sub-module: rr_arb2, a combinational 2-way round-robin grant taking (valid0, valid1, last_grant) and producing (grant_valid, grant_id).
- The FSM, operand registers and response registers stay in the top module.
- Testbench instantiates arithmetic_unit as the real datapath behind au_*.

Test Plan:
- Reset then idle: assert rst_n=0 mid-EXEC with req0 valid (a=8'h10, b=8'h20, op=00) -> immediately rsp_valid=0, busy=0, au_*=0; after release, the operation is re-accepted from IDLE and no stale response appears.
- Single add: req0 a=8'h7F, b=8'h01, op=00, rsp_ready=1 -> req0_ready one cycle; 2 cycles later rsp_id=0, rsp_result=8'h80, rsp_nzvc=4'b1010.
- Subtract to zero: req1 a=8'h05, b=8'h05, op=10 -> rsp_id=1, rsp_result=8'h00, rsp_nzvc=4'b0101.
- Contention/fairness: both valid continuously (PRIO_INIT=0) for 4 operations -> grant order 0,1,0,1; each requester's ready pulses exactly twice; never both ready in one cycle.
- Back-pressure: rsp_ready=0 for 5 cycles in RESP with req0 decrement of 8'h00 -> rsp_result=8'hFF and rsp_nzvc=4'b1000 held stable throughout; no reqN_ready until 1 cycle after rsp_ready=1 handshake.
- Increment wrap: req0 a=8'hFF, op=01 -> rsp_result=8'h00, rsp_nzvc=4'b0101.

Source files
------------

// File: rtl/alu_rr_arbiter_pkg.sv
// Shared encodings for the two-requester ALU arbiter and its arithmetic unit.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package alu_rr_arbiter_pkg;

  // Operation select values understood by arithmetic_unit
  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_INC = 2'b01;
  localparam logic [1:0] OP_SUB = 2'b10;
  localparam logic [1:0] OP_DEC = 2'b11;

  // Bit positions inside the 4-bit {N,Z,V,C} flag vector
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_V = 1;
  localparam int FLAG_C = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_RESP = 2'b10
  } state_e;

  // Everything the response channel carries besides the valid bit
  typedef struct packed {
    logic       id;
    logic [7:0] result;
    logic [3:0] nzvc;
  } rsp_t;

endpackage

// File: rtl/alu_rr_arbiter_rr_arb2.sv
// Two-way round-robin grant: a lone requester wins, a tie goes to the one not served last.
// Latency: purely combinational.
// Backpressure: none; caller decides when the grant is consumed.
module rr_arb2 (
  input  logic valid0,
  input  logic valid1,
  input  logic last_grant,
  output logic grant_valid,
  output logic grant_id
);

  // Tie-break flips away from the previous winner so a waiting loser is served next
  always_comb begin
    grant_valid = valid0 | valid1;
    grant_id    = 1'b0;
    if (valid0 && valid1) begin
      grant_id = ~last_grant;
    end else if (valid1) begin
      grant_id = 1'b1;
    end
  end

endmodule

// File: rtl/arithmetic_unit.sv
// Shared 8-bit add/increment/subtract/decrement unit with NZVC flags.
// Latency: purely combinational.
// Backpressure: none; output follows the inputs.
module arithmetic_unit
  import alu_rr_arbiter_pkg::*;
(
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic [1:0] sel,
  output logic [7:0] result,
  output logic [3:0] nzvc
);

  logic [7:0] opnd;
  logic [7:0] opnd_eff;
  logic       is_sub;
  logic [8:0] sum;

  // Subtraction is a + ~b + 1, so carry-out means "no borrow"
  always_comb begin
    opnd   = b;
    is_sub = 1'b0;
    case (sel)
      OP_ADD: begin opnd = b;     is_sub = 1'b0; end
      OP_INC: begin opnd = 8'h01; is_sub = 1'b0; end
      OP_SUB: begin opnd = b;     is_sub = 1'b1; end
      OP_DEC: begin opnd = 8'h01; is_sub = 1'b1; end
      default: begin opnd = b;    is_sub = 1'b0; end
    endcase
    opnd_eff = is_sub ? ~opnd : opnd;
    sum      = {1'b0, a} + {1'b0, opnd_eff} + {8'd0, is_sub};
    result   = sum[7:0];
    nzvc          = 4'b0000;
    nzvc[FLAG_N]  = sum[7];
    nzvc[FLAG_Z]  = (sum[7:0] == 8'h00);
    nzvc[FLAG_V]  = (a[7] == opnd_eff[7]) && (sum[7] != a[7]);
    nzvc[FLAG_C]  = sum[8];
  end

endmodule

// File: rtl/alu_rr_arbiter.sv
// Shares one arithmetic unit between two requesters, returning tagged results.
// Latency: accept at edge T, response valid after edge T+1; one op per 3 cycles peak.
// Backpressure: rsp_ready low parks the FSM in RESP and holds both reqN_ready low.
module alu_rr_arbiter
  import alu_rr_arbiter_pkg::*;
#(
  parameter int PRIO_INIT = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0_valid,
  output logic       req0_ready,
  input  logic [7:0] req0_a,
  input  logic [7:0] req0_b,
  input  logic [1:0] req0_op,
  input  logic       req1_valid,
  output logic       req1_ready,
  input  logic [7:0] req1_a,
  input  logic [7:0] req1_b,
  input  logic [1:0] req1_op,
  output logic [7:0] au_a,
  output logic [7:0] au_b,
  output logic [1:0] au_sel,
  input  logic [7:0] au_result,
  input  logic [3:0] au_nzvc,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic       rsp_id,
  output logic [7:0] rsp_result,
  output logic [3:0] rsp_nzvc,
  output logic       busy
);

  // Reset value of last_grant makes PRIO_INIT the winner of the first tie
  localparam logic LAST_GRANT_RST = (PRIO_INIT == 0) ? 1'b1 : 1'b0;

  state_e     state_q,      state_d;
  logic       last_grant_q, last_grant_d;
  logic [7:0] au_a_q,       au_a_d;
  logic [7:0] au_b_q,       au_b_d;
  logic [1:0] au_sel_q,     au_sel_d;
  rsp_t       rsp_q,        rsp_d;
  logic       rsp_valid_q,  rsp_valid_d;
  logic       busy_q,       busy_d;

  logic grant_valid;
  logic grant_id;
  logic accept;

  rr_arb2 u_rr_arb2 (
    .valid0      (req0_valid),
    .valid1      (req1_valid),
    .last_grant  (last_grant_q),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  // Readies are gated by reset so nothing looks accepted while rst_n is low
  always_comb begin
    accept     = rst_n && (state_q == ST_IDLE) && grant_valid;
    req0_ready = accept && (grant_id == 1'b0);
    req1_ready = accept && (grant_id == 1'b1);
  end

  // Next-state: latch operands on accept, capture unit output in EXEC, wait for consumer in RESP
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    au_a_d       = au_a_q;
    au_b_d       = au_b_q;
    au_sel_d     = au_sel_q;
    rsp_d        = rsp_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          au_a_d       = grant_id ? req1_a  : req0_a;
          au_b_d       = grant_id ? req1_b  : req0_b;
          au_sel_d     = grant_id ? req1_op : req0_op;
          rsp_d.id     = grant_id;
          last_grant_d = grant_id;
          state_d      = ST_EXEC;
        end
      end
      ST_EXEC: begin
        rsp_d.result = au_result;
        rsp_d.nzvc   = au_nzvc;
        state_d      = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    rsp_valid_d = (state_d == ST_RESP);
    busy_d      = (state_d != ST_IDLE);
  end

  // All state and registered outputs; reset drops any in-flight op or pending response
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      last_grant_q <= LAST_GRANT_RST;
      au_a_q       <= 8'h00;
      au_b_q       <= 8'h00;
      au_sel_q     <= 2'b00;
      rsp_q        <= '0;
      rsp_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      au_a_q       <= au_a_d;
      au_b_q       <= au_b_d;
      au_sel_q     <= au_sel_d;
      rsp_q        <= rsp_d;
      rsp_valid_q  <= rsp_valid_d;
      busy_q       <= busy_d;
    end
  end

  assign au_a       = au_a_q;
  assign au_b       = au_b_q;
  assign au_sel     = au_sel_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_id     = rsp_q.id;
  assign rsp_result = rsp_q.result;
  assign rsp_nzvc   = rsp_q.nzvc;
  assign busy       = busy_q;

endmodule
